// File: rtl/jh512_padder.sv
// JH512 message padder: packs 64-bit words into 512-bit blocks and emits them as four 128-bit beats.
// Optional block counter output enabled by defining JH512_PADDER_BLKCNT_EN.
module jh512_padder #(
   parameter int LEN_W = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   input  logic [3:0]    in_bytes,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic [1:0]    out_beat,
   output logic          out_msg_first,
   output logic          out_blk_last
`ifdef JH512_PADDER_BLKCNT_EN
   ,
   output logic [31:0]   blk_count
`endif
);

   typedef enum logic [1:0] {FILL, PAD, EMIT, LENBLK} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [511:0]       blk;
   logic [2:0]         wi;
   logic [LEN_W-1:0]   cnt;
   logic               msg_first;
   logic               need80;
   logic               len_pending;
   logic               blk_last;
   logic [1:0]         beat;
   logic [5:0]         pad_off;

   logic               in_fire;
   logic               out_fire;
   logic               beat_done;
   logic [6:0]         off;
   logic [63:0]        word_masked;
   logic [127:0]       len_bits;

   assign in_fire   = (state == FILL) && in_valid;
   assign out_fire  = (state == EMIT) && out_ready;
   assign beat_done = out_fire && (beat == 2'd3);
   assign off       = {1'b0, wi, 3'b000} + {3'b000, in_bytes};
   assign len_bits  = 128'({cnt, 3'b000});

   // Bytes past the valid count are forced to zero so stale data never leaks into a block
   always_comb begin
      word_masked = '0;
      for (int b = 0; b < 8; b++) begin
         if (4'(b) < in_bytes)
            word_masked[63-8*b -: 8] = in_data[63-8*b -: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= FILL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: begin
            if (in_valid) begin
               if (in_last) begin
                  if (off == 7'd64)
                     state_nxt = EMIT;
                  else if (off == 7'd0)
                     state_nxt = LENBLK;
                  else
                     state_nxt = PAD;
               end else if (wi == 3'd7) begin
                  state_nxt = EMIT;
               end
            end
         end
         PAD:    state_nxt = EMIT;
         EMIT: begin
            if (beat_done) begin
               if (blk_last)
                  state_nxt = FILL;
               else if (len_pending)
                  state_nxt = LENBLK;
               else
                  state_nxt = FILL;
            end
         end
         LENBLK: state_nxt = EMIT;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready      = (state == FILL);
      out_valid     = (state == EMIT);
      out_beat      = '0;
      out_data      = '0;
      out_msg_first = 1'b0;
      out_blk_last  = 1'b0;
      if (state == EMIT) begin
         out_beat      = beat;
         out_msg_first = msg_first;
         out_blk_last  = blk_last;
         case (beat)
            2'd0:    out_data = blk[511:384];
            2'd1:    out_data = blk[383:256];
            2'd2:    out_data = blk[255:128];
            default: out_data = blk[127:0];
         endcase
      end
   end

   // Every last word leaves a length block pending; the empty message skips straight to it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk         <= '0;
         wi          <= '0;
         cnt         <= '0;
         msg_first   <= 1'b1;
         need80      <= 1'b0;
         len_pending <= 1'b0;
         blk_last    <= 1'b0;
         beat        <= '0;
         pad_off     <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_fire) begin
                  blk[{~wi, 6'h3f} -: 64] <= word_masked;
                  cnt         <= cnt + LEN_W'(in_bytes);
                  wi          <= wi + 3'd1;
                  blk_last    <= 1'b0;
                  len_pending <= in_last;
                  if (in_last) begin
                     wi      <= '0;
                     pad_off <= off[5:0];
                     need80  <= (off == 7'd64) || (off == 7'd0);
                  end
               end
            end
            PAD: begin
               for (int b = 0; b < 64; b++) begin
                  if (6'(b) == pad_off)
                     blk[511-8*b -: 8] <= 8'h80;
                  else if (6'(b) > pad_off)
                     blk[511-8*b -: 8] <= 8'h00;
               end
            end
            EMIT: begin
               if (out_fire) begin
                  beat <= beat + 2'd1;
                  if (beat == 2'd3) begin
                     msg_first <= 1'b0;
                     if (blk_last) begin
                        cnt       <= '0;
                        wi        <= '0;
                        msg_first <= 1'b1;
                        blk_last  <= 1'b0;
                     end else if (len_pending) begin
                        len_pending <= 1'b0;
                     end
                  end
               end
            end
            LENBLK: begin
               blk      <= {(need80 ? 8'h80 : 8'h00), 376'b0, len_bits};
               blk_last <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef JH512_PADDER_BLKCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blk_count <= '0;
      else if (beat_done)
         blk_count <= blk_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_jh512_padder.sv
// Directed self-checking bench for jh512_padder: reset, padding cases, stall and mid-block reset.
`timescale 1ns/1ps
module tb_jh512_padder;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic [3:0]    in_bytes;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_data;
   logic [1:0]    out_beat;
   logic          out_msg_first;
   logic          out_blk_last;
`ifdef JH512_PADDER_BLKCNT_EN
   logic [31:0]   blk_count;
`endif

   int checks;
   int failures;
   int send_timeouts;

   logic [127:0]  cap_data[4];
   logic [1:0]    cap_beat[4];
   logic          cap_first[4];
   logic          cap_last[4];
   int            cap_n;
   bit            cap_timeout;
   bit            stall_changed;
   bit            stall_ready_seen;

   jh512_padder #(.LEN_W(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_bytes      (in_bytes),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_beat      (out_beat),
      .out_msg_first (out_msg_first),
      .out_blk_last  (out_blk_last)
`ifdef JH512_PADDER_BLKCNT_EN
      ,
      .blk_count     (blk_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic send_word(input logic [63:0] d, input logic [3:0] b, input logic l);
      int budget;
      budget = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_bytes = b;
      in_last  = l;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         send_timeouts++;
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic collect_block(input int stall_at);
      int budget;
      bit stalled;
      logic [127:0] hold_d;
      logic [1:0] hold_b;
      cap_n = 0;
      cap_timeout = 0;
      stall_changed = 0;
      stall_ready_seen = 0;
      stalled = 0;
      budget = 0;
      out_ready = 1'b1;
      while (cap_n < 4 && !cap_timeout) begin
         @(negedge clk);
         budget++;
         if (budget > 200) begin
            cap_timeout = 1;
         end else if (out_valid) begin
            if (!stalled && int'(out_beat) == stall_at) begin
               stalled = 1;
               out_ready = 1'b0;
               hold_d = out_data;
               hold_b = out_beat;
               repeat (5) begin
                  @(negedge clk);
                  if (out_data !== hold_d || out_beat !== hold_b || out_valid !== 1'b1)
                     stall_changed = 1;
                  if (in_ready !== 1'b0)
                     stall_ready_seen = 1;
               end
               out_ready = 1'b1;
            end
            cap_data[cap_n]  = out_data;
            cap_beat[cap_n]  = out_beat;
            cap_first[cap_n] = out_msg_first;
            cap_last[cap_n]  = out_blk_last;
            cap_n++;
         end
      end
   endtask

   function automatic logic [63:0] seq_word(input int w);
      logic [63:0] d;
      for (int b = 0; b < 8; b++) d[63-8*b -: 8] = 8'(8*w + b);
      return d;
   endfunction

   function automatic logic [127:0] seq_beat(input int k);
      logic [127:0] d;
      for (int j = 0; j < 16; j++) d[127-8*j -: 8] = 8'(16*k + j);
      return d;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 128'h0 || out_beat !== 2'd0 ||
          out_msg_first !== 1'b0 || out_blk_last !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs valid=%b data=%h beat=%0d first=%b last=%b required all zero",
                  out_valid, out_data, out_beat, out_msg_first, out_blk_last);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready got=%b required 1", in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL post_reset in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_empty;
      logic [127:0] e[4];
      bit extra;
      e[0] = {8'h80, 120'h0}; e[1] = '0; e[2] = '0; e[3] = '0;
      send_timeouts = 0;
      send_word(64'h0123456789abcdef, 4'd0, 1'b1);
      collect_block(-1);
      checks++;
      if (cap_timeout || send_timeouts != 0) begin
         failures++;
         $display("[TB] FAIL empty_timeout beats=%0d send_timeouts=%0d required 4/0", cap_n, send_timeouts);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b1 || cap_last[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL empty_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/1/1",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b0) extra = 1;
      end
      checks++;
      if (extra) begin
         failures++;
         $display("[TB] FAIL empty_extra_block got out_valid=1 required 0");
      end
   endtask

   task automatic test_abc;
      logic [127:0] e[4];
      send_timeouts = 0;
      send_word(64'h6162630000000000, 4'd3, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abc_pad_cycle got out_valid=%b required 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abc_latency got out_valid=%b required 1", out_valid);
      end
      e[0] = {32'h61626380, 96'h0}; e[1] = '0; e[2] = '0; e[3] = '0;
      collect_block(-1);
      checks++;
      if (cap_timeout || send_timeouts != 0) begin
         failures++;
         $display("[TB] FAIL abc_b1_timeout beats=%0d required 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b1 || cap_last[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abc_b1_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/1/0",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
      e[0] = '0; e[1] = '0; e[2] = '0; e[3] = 128'h18;
      collect_block(-1);
      checks++;
      if (cap_timeout) begin
         failures++;
         $display("[TB] FAIL abc_b2_timeout beats=%0d required 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b0 || cap_last[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abc_b2_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/0/1",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
   endtask

   task automatic test_full_block(input int stall_at);
      logic [127:0] e[4];
      send_timeouts = 0;
      for (int w = 0; w < 8; w++) send_word(seq_word(w), 4'd8, (w == 7));
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL full_latency got out_valid=%b required 1", out_valid);
      end
      for (int k = 0; k < 4; k++) e[k] = seq_beat(k);
      collect_block(stall_at);
      checks++;
      if (cap_timeout || send_timeouts != 0) begin
         failures++;
         $display("[TB] FAIL full_b1_timeout beats=%0d required 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b1 || cap_last[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_b1_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/1/0",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
      if (stall_at >= 0) begin
         checks++;
         if (stall_changed) begin
            failures++;
            $display("[TB] FAIL stall_hold got changed=1 required 0");
         end
         checks++;
         if (stall_ready_seen) begin
            failures++;
            $display("[TB] FAIL stall_in_ready got 1 required 0");
         end
      end
      e[0] = {8'h80, 120'h0}; e[1] = '0; e[2] = '0; e[3] = 128'h200;
      collect_block(-1);
      checks++;
      if (cap_timeout) begin
         failures++;
         $display("[TB] FAIL full_b2_timeout beats=%0d required 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b0 || cap_last[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_b2_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/0/1",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
   endtask

   task automatic test_half_block;
      logic [127:0] e[4];
      send_timeouts = 0;
      for (int w = 0; w < 4; w++) send_word(seq_word(w), 4'd8, (w == 3));
      e[0] = seq_beat(0); e[1] = seq_beat(1); e[2] = {8'h80, 120'h0}; e[3] = '0;
      collect_block(-1);
      checks++;
      if (cap_timeout || send_timeouts != 0) begin
         failures++;
         $display("[TB] FAIL half_b1_timeout beats=%0d required 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_data[i] !== e[i] || cap_beat[i] !== 2'(i) || cap_first[i] !== 1'b1 || cap_last[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL half_b1_beat%0d got data=%h beat=%0d first=%b last=%b required %h/%0d/1/0",
                     i, cap_data[i], cap_beat[i], cap_first[i], cap_last[i], e[i], i);
         end
      end
      e[0] = '0; e[1] = '0; e[2] = '0; e[3] = 128'h100;
      collect_block(-1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_timeout || cap_data[i] !== e[i] || cap_first[i] !== 1'b0 || cap_last[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL half_b2_beat%0d got data=%h first=%b last=%b required %h/0/1",
                     i, cap_data[i], cap_first[i], cap_last[i], e[i]);
         end
      end
   endtask

   task automatic test_partial_mask;
      logic [127:0] e[4];
      send_timeouts = 0;
      send_word(seq_word(0), 4'd8, 1'b0);
      send_word(64'h08ffffffffffffff, 4'd1, 1'b1);
      e[0] = {64'h0001020304050607, 64'h0880000000000000}; e[1] = '0; e[2] = '0; e[3] = '0;
      collect_block(-1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_timeout || send_timeouts != 0 || cap_data[i] !== e[i] || cap_first[i] !== 1'b1 || cap_last[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mask_b1_beat%0d got data=%h first=%b last=%b required %h/1/0",
                     i, cap_data[i], cap_first[i], cap_last[i], e[i]);
         end
      end
      e[0] = '0; e[1] = '0; e[2] = '0; e[3] = 128'h48;
      collect_block(-1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_timeout || cap_data[i] !== e[i] || cap_first[i] !== 1'b0 || cap_last[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mask_b2_beat%0d got data=%h first=%b last=%b required %h/0/1",
                     i, cap_data[i], cap_first[i], cap_last[i], e[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int budget;
      bit found;
      send_timeouts = 0;
      send_word(64'h6162630000000000, 4'd3, 1'b1);
      out_ready = 1'b1;
      budget = 0;
      found = 0;
      while (!found && budget < 200) begin
         @(negedge clk);
         budget++;
         if (out_valid === 1'b1 && out_beat === 2'd1) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL midrst_reach_beat1 got found=0 required 1");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_async got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_abc();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      send_timeouts = 0;
      in_valid = 1'b0;
      in_data = '0;
      in_bytes = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      test_reset();
      test_empty();
      test_abc();
      test_full_block(-1);
      test_half_block();
      test_partial_mask();
      test_full_block(2);
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
